// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding and a width helper.
package mux_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index searching upward from ptr+1, wrapping.
module rr_pick import mux_arb_pkg::*; #(
    parameter int N     = 4,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Farthest candidate first, so the nearest eligible one after ptr is written last.
        for (int k = N; k >= 1; k--) begin
            cand = SEL_W'((int'(ptr) + k) % N);
            if (elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared word mux, with a registered output word.
// Define MUX_RR_ARBITER_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module mux_rr_arbiter import mux_arb_pkg::*; #(
    parameter int  N        = 4,
    parameter int  W        = 8,
    parameter int  MAX_HOLD = 16,
    localparam int SEL_W    = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data_in,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic [W-1:0]     data_out,
    output logic             valid_out,
    output logic             busy,
    output logic             timeout
);

    if (N < 2 || N > 8 || MAX_HOLD < 2) begin : g_bad_params
        $error("mux_rr_arbiter: N must be 2..8 and MAX_HOLD at least 2");
    end

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     elig;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [W-1:0]     words [N];

    for (genvar i = 0; i < N; i++) begin : g_words
        assign words[i] = data_in[i*W +: W];
    end

`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     mask_q, mask_d;
    logic             timeout_q, timeout_d;

    // A timed-out requester stays ineligible until it drops req.
    assign elig = req & ~mask_q;
`else
    assign elig = req;
`endif

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
        mask_d    = mask_q & req;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    sel_d           = pick_idx;
                    state_d         = S_GRANT;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            S_GRANT: begin
                data_d  = words[sel_q];
                valid_d = 1'b1;
                // A normal release takes priority over a timeout on the same cycle.
                if (!req[sel_q]) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                    state_d = S_IDLE;
                end
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    gnt_d         = '0;
                    valid_d       = 1'b0;
                    timeout_d     = 1'b1;
                    mask_d[sel_q] = 1'b1;
                    ptr_d         = sel_q;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N - 1);
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == S_GRANT);
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: behavioural model checked every cycle plus directed literal expectations.
module tb_mux_rr_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 16;
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [W-1:0]   words [N];
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic [W-1:0]   data_out;
    logic           valid_out;
    logic           busy;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    assign data_in = {words[3], words[2], words[1], words[0]};

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Model: who owns the channel, whose turn is next, and what the outputs must be.
    bit           m_busy  = 1'b0;
    logic [1:0]   m_sel   = 2'd0;
    logic [1:0]   m_ptr   = 2'(N - 1);
    int           m_cnt   = 0;
    logic [N-1:0] m_mask  = '0;
    logic [W-1:0] m_data  = '0;
    bit           m_valid = 1'b0;
    bit           m_to    = 1'b0;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_sel   = 2'd0;
        m_ptr   = 2'(N - 1);
        m_cnt   = 0;
        m_mask  = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] c;
        bit found;
        m_to  = 1'b0;
        found = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = m_ptr + 2'(k);
                if (!found && req[c] && !m_mask[c]) begin
                    found = 1'b1;
                    m_sel = c;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            m_data = words[m_sel];
            if (!req[m_sel]) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_ptr   = m_sel;
            end else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_to    = 1'b1;
                m_ptr   = m_sel;
            end else begin
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1;
            end
        end
        m_mask = m_mask & req;
        if (m_to) m_mask[m_sel] = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_gnt", 32'(gnt), 32'(m_busy ? (4'b0001 << m_sel) : 4'b0000));
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_valid", 32'(valid_out), 32'(m_valid));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_timeout", 32'(timeout), 32'(m_to));
        if (m_valid) chk("model_data", 32'(data_out), 32'(m_data));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int order[$];
        int gaps[$];
        int exp_order[$];
        int n;
        int hold;
        int idle;
        int idx;
        int g3_cycles;
        int to_pulses;
        int g3_rises;
        logic [N-1:0] prev;
        logic [N-1:0] other;

        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        words[3] = 8'h44;

        // Reset with every requester asking.
        req = 4'b1111;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        tick();
        chk("first_data", 32'(data_out), 32'h11);
        chk("first_valid", 32'(valid_out), 32'h1);
        req = 4'b0000;
        tick();
        chk("first_release_gnt", 32'(gnt), 32'h0);
        tick();

        // Single requester 2 for three cycles.
        words[2] = 8'hA5;
        req      = 4'b0100;
        tick();
        chk("r2_gnt0", 32'(gnt), 32'h4);
        repeat (2) begin
            tick();
            chk("r2_gnt", 32'(gnt), 32'h4);
            chk("r2_data", 32'(data_out), 32'hA5);
            chk("r2_valid", 32'(valid_out), 32'h1);
        end
        req = 4'b0000;
        tick();
        chk("r2_drop_gnt", 32'(gnt), 32'h0);
        chk("r2_drop_valid", 32'(valid_out), 32'h0);
        chk("r2_drop_busy", 32'(busy), 32'h0);
        tick();

        // Asynchronous reset in the middle of requester 1's grant.
        req = 4'b0010;
        tick();
        chk("r1_gnt", 32'(gnt), 32'h2);
        tick();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_valid", 32'(valid_out), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_data", 32'(data_out), 32'h0);
        tick();
        req   = 4'b1111;
        rst_n = 1'b1;

        // All requesting, each releasing after two granted cycles.
        n    = 0;
        hold = 0;
        idle = 0;
        prev = '0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (gnt != 4'b0000) begin
                if (prev == 4'b0000) begin
                    case (gnt)
                        4'b0001: idx = 0;
                        4'b0010: idx = 1;
                        4'b0100: idx = 2;
                        4'b1000: idx = 3;
                        default: idx = -1;
                    endcase
                    order.push_back(idx);
                    if (n > 0) gaps.push_back(idle);
                    n++;
                    idle = 0;
                end
                hold++;
                if (hold == 2) begin
                    req  = 4'b1111 & ~gnt;
                    hold = 0;
                end
            end else begin
                idle++;
                hold = 0;
                req  = (n == 5) ? 4'b0000 : 4'b1111;
            end
            prev = gnt;
            if (n == 5 && gnt == 4'b0000) break;
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_grant_count", 32'(n), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) begin
            chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
        end
        for (int i = 0; i < gaps.size(); i++) begin
            chk("rr_bubble", 32'(gaps[i]), 32'd1);
        end
        tick();

        // Requesters 3 and 0 held high for 40 cycles.
        req       = 4'b1001;
        g3_cycles = 0;
        to_pulses = 0;
        g3_rises  = 0;
        prev      = '0;
        other     = '0;
        repeat (40) begin
            tick();
            if (gnt == 4'b1000) g3_cycles++;
            if (gnt[3] && !prev[3]) g3_rises++;
            if (timeout) to_pulses++;
            if (other == 4'b0000 && gnt != 4'b0000 && gnt != 4'b1000) other = gnt;
            prev = gnt;
        end
`ifdef MUX_RR_ARBITER_TIMEOUT_EN
        chk("hold_g3_cycles", 32'(g3_cycles), 32'd16);
        chk("hold_timeouts", 32'(to_pulses), 32'd2);
        chk("hold_next_gnt", 32'(other), 32'h1);
`else
        chk("hold_g3_cycles", 32'(g3_cycles), 32'd40);
        chk("hold_timeouts", 32'(to_pulses), 32'd0);
        chk("hold_next_gnt", 32'(other), 32'h0);
`endif
        chk("hold_g3_rises", 32'(g3_rises), 32'd1);

        req = 4'b0000;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
